// File: rtl/fp_op_arbiter.sv
// Round-robin front end that shares one fixed-latency FP operator between NREQ requesters.
// A tag pipe follows each issued operation so its result returns to the requester that issued it.
module fp_op_arbiter #(
    parameter int NX   = 8,
    parameter int NM   = 23,
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*(NX+NM+1)-1:0] req_a,
    input  logic [NREQ*(NX+NM+1)-1:0] req_b,
    output logic                  fpu_valid,
    output logic [NX+NM:0]        fpu_a,
    output logic [NX+NM:0]        fpu_b,
    input  logic [NX+NM:0]        fpu_res,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NX+NM:0]        rsp_data,
    output logic                  busy
);
    localparam int N  = NX + NM + 1;
    localparam int OW = $clog2(NREQ);

    logic [OW-1:0]   rr_q, rr_d;
    logic            fpu_valid_q, fpu_valid_d;
    logic [N-1:0]    fpu_a_q, fpu_a_d;
    logic [N-1:0]    fpu_b_q, fpu_b_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [N-1:0]    rsp_data_q, rsp_data_d;
    logic [LAT:0]    tag_vld_q, tag_vld_d;
    logic [OW-1:0]   tag_own_q [0:LAT];
    logic [OW-1:0]   tag_own_d [0:LAT];

    logic            found;
    logic            hs;
    logic [OW-1:0]   gnt_idx;
    logic [NREQ-1:0] grant;
    logic [N-1:0]    sel_a, sel_b;

    // Rotating priority scan starting at the round-robin pointer.
    always_comb begin
        int idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[OW'(idx)]) begin
                found   = 1'b1;
                gnt_idx = OW'(idx);
            end
        end
        hs    = found && !flush && !rst;
        grant = '0;
        if (hs) begin
            grant[gnt_idx] = 1'b1;
        end
        sel_a = req_a[int'(gnt_idx)*N +: N];
        sel_b = req_b[int'(gnt_idx)*N +: N];
    end

    always_comb begin
        rr_d        = rr_q;
        fpu_valid_d = hs;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        if (hs) begin
            rr_d    = (gnt_idx == OW'(NREQ - 1)) ? '0 : gnt_idx + OW'(1);
            fpu_a_d = sel_a;
            fpu_b_d = sel_b;
        end

        tag_vld_d[0] = hs;
        tag_own_d[0] = gnt_idx;
        for (int k = 1; k <= LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_own_d[k] = tag_own_q[k-1];
        end
        if (flush) begin
            tag_vld_d = '0;
        end

        // The last tag stage lines up with the FP unit result for that operation.
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_vld_q[LAT] && !flush) begin
            rsp_valid_d[tag_own_q[LAT]] = 1'b1;
            rsp_data_d                  = fpu_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= '0;
            fpu_valid_q <= 1'b0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            tag_vld_q   <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_own_q[k] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            fpu_valid_q <= fpu_valid_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tag_vld_q   <= tag_vld_d;
            for (int k = 0; k <= LAT; k++) begin
                tag_own_q[k] <= tag_own_d[k];
            end
        end
    end

    assign req_ready = grant;
    assign fpu_valid = fpu_valid_q;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = |tag_vld_q;
endmodule

// File: tb/tb_fp_op_arbiter.sv
// Directed bench for fp_op_arbiter: a 4-requester/LAT=3 instance and a 3-requester/LAT=1 instance,
// each driving a behavioural single-precision adder stub.
module tb_fp_op_arbiter;
    localparam int N = 32;

    localparam logic [31:0] F0_5 = 32'h3F000000;
    localparam logic [31:0] F1   = 32'h3F800000;
    localparam logic [31:0] F1_5 = 32'h3FC00000;
    localparam logic [31:0] F2   = 32'h40000000;
    localparam logic [31:0] F2_5 = 32'h40200000;
    localparam logic [31:0] F3   = 32'h40400000;
    localparam logic [31:0] F3_5 = 32'h40600000;
    localparam logic [31:0] F4   = 32'h40800000;
    localparam logic [31:0] F5   = 32'h40A00000;
    localparam logic [31:0] F6   = 32'h40C00000;
    localparam logic [31:0] F7   = 32'h40E00000;
    localparam logic [31:0] F8   = 32'h41000000;

    localparam logic [31:0] A4   [4] = '{F1, F2, F3, F4};
    localparam logic [31:0] SUM4 [4] = '{F5, F6, F7, F8};
    localparam logic [31:0] A3   [3] = '{F1, F2, F3};
    localparam logic [31:0] SUM3 [3] = '{F1_5, F2_5, F3_5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, flush3;

    logic [3:0]    rv4, rdy4, rspv4;
    logic [4*N-1:0] ra4, rb4;
    logic          fv4, busy4;
    logic [N-1:0]  fa4, fb4, fres4, rspd4;

    logic [2:0]    rv3, rdy3, rspv3;
    logic [3*N-1:0] ra3, rb3;
    logic          fv3, busy3;
    logic [N-1:0]  fa3, fb3, fres3, rspd3;

    int tests = 0;
    int fails = 0;

    fp_op_arbiter #(.NX(8), .NM(23), .NREQ(4), .LAT(3)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(rv4), .req_ready(rdy4), .req_a(ra4), .req_b(rb4),
        .fpu_valid(fv4), .fpu_a(fa4), .fpu_b(fb4), .fpu_res(fres4),
        .rsp_valid(rspv4), .rsp_data(rspd4), .busy(busy4)
    );

    fp_op_arbiter #(.NX(8), .NM(23), .NREQ(3), .LAT(1)) dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .req_valid(rv3), .req_ready(rdy3), .req_a(ra3), .req_b(rb3),
        .fpu_valid(fv3), .fpu_a(fa3), .fpu_b(fb3), .fpu_res(fres3),
        .rsp_valid(rspv3), .rsp_data(rspd3), .busy(busy3)
    );

    // Single-precision <-> real conversion for normal numbers and zero.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'h0) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    logic [31:0] p4 [0:2];
    logic [31:0] p3;
    always_ff @(posedge clk) begin
        p4[0] <= r2f(f2r(fa4) + f2r(fb4));
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p3    <= r2f(f2r(fa3) + f2r(fb3));
    end
    assign fres4 = p4[2];
    assign fres3 = p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ops();
        for (int i = 0; i < 4; i++) begin
            ra4[i*N +: N] = A4[i];
            rb4[i*N +: N] = F4;
        end
        for (int i = 0; i < 3; i++) begin
            ra3[i*N +: N] = A3[i];
            rb3[i*N +: N] = F0_5;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rvseq  [5];
        logic [3:0] expseq [5];
        int o;
        rvseq  = '{4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b0010};
        expseq = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0010};

        rst = 1'b1; flush = 1'b0; flush3 = 1'b0;
        rv4 = 4'b1111; rv3 = 3'b111;
        load_ops();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdy4", 32'(rdy4), 32'd0);
        chk("reset_rdy3", 32'(rdy3), 32'd0);
        chk("reset_fv4", 32'(fv4), 32'd0);
        chk("reset_fa4", fa4, 32'd0);
        chk("reset_rspv4", 32'(rspv4), 32'd0);
        chk("reset_rspd4", rspd4, 32'd0);
        chk("reset_busy4", 32'(busy4), 32'd0);
        step();
        rst = 1'b0; rv4 = 4'b0000; rv3 = 3'b000;

        // NREQ=3, LAT=1: continuous requests, wrap 2->0, response at h+3.
        for (int c = 0; c < 11; c++) begin
            step();
            rv3 = (c < 7) ? 3'b111 : 3'b000;
            @(negedge clk);
            if (c < 7) chk("n3_grant", 32'(rdy3), 32'd1 << (c % 3));
            if (c >= 3 && c <= 9) begin
                chk("n3_rsp_owner", 32'(rspv3), 32'd1 << ((c - 3) % 3));
                chk("n3_rsp_data", rspd3, SUM3[(c - 3) % 3]);
            end else begin
                chk("n3_rsp_idle", 32'(rspv3), 32'd0);
            end
            chk("n3_rsp_onehot", 32'($onehot0(rspv3)), 32'd1);
        end

        // Single issue from requester 2: 1.0 + 2.0.
        step();
        ra4[2*N +: N] = F1; rb4[2*N +: N] = F2; rv4 = 4'b0100;
        @(negedge clk);
        chk("single_grant", 32'(rdy4), 32'b0100);
        for (int c = 1; c <= 6; c++) begin
            step();
            rv4 = 4'b0000;
            @(negedge clk);
            chk("single_busy", 32'(busy4), 32'(c <= 4));
            chk("single_rspv", 32'(rspv4), (c == 5) ? 32'b0100 : 32'd0);
            if (c == 1) begin
                chk("single_fv", 32'(fv4), 32'd1);
                chk("single_fa", fa4, F1);
                chk("single_fb", fb4, F2);
            end
            if (c >= 5) chk("single_rspd", rspd4, F3);
        end
        load_ops();

        // All four requesters for 12 cycles; pointer starts at 3.
        for (int c = 0; c < 18; c++) begin
            step();
            rv4 = (c < 12) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 12) chk("rr_grant", 32'(rdy4), 32'd1 << ((3 + c) % 4));
            if (c >= 1 && c <= 12) begin
                chk("rr_fv", 32'(fv4), 32'd1);
                chk("rr_fa", fa4, A4[(3 + c - 1) % 4]);
            end
            if (c >= 5 && c <= 16) begin
                o = (3 + c - 5) % 4;
                chk("rr_rsp_owner", 32'(rspv4), 32'd1 << o);
                chk("rr_rsp_data", rspd4, SUM4[o]);
            end else begin
                chk("rr_rsp_idle", 32'(rspv4), 32'd0);
            end
        end

        // Sparse pattern: pointer reaches 1, then only requesters 0 and 3 compete.
        for (int i = 0; i < 5; i++) begin
            step();
            rv4 = rvseq[i];
            @(negedge clk);
            chk("sparse_grant", 32'(rdy4), 32'(expseq[i]));
            if (i > 0) chk("sparse_fv", 32'(fv4), 32'd1);
        end
        step();
        rv4 = 4'b0000;
        @(negedge clk);
        chk("sparse_fv_last", 32'(fv4), 32'd1);
        chk("sparse_fa_last", fa4, A4[1]);
        repeat (5) step();
        @(negedge clk);
        chk("sparse_drained", 32'(busy4), 32'd0);

        // Three issues, flush, then one fresh request (pointer at 2).
        for (int i = 0; i < 3; i++) begin
            step();
            rv4 = 4'b1111;
            @(negedge clk);
            chk("pre_flush_grant", 32'(rdy4), 32'd1 << ((2 + i) % 4));
        end
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_no_grant", 32'(rdy4), 32'd0);
        chk("flush_fv", 32'(fv4), 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_busy", 32'(busy4), 32'd0);
        chk("post_flush_fv", 32'(fv4), 32'd0);
        chk("post_flush_grant", 32'(rdy4), 32'b0010);
        for (int d = 2; d <= 6; d++) begin
            step();
            rv4 = 4'b0000;
            @(negedge clk);
            chk("flush_rspv", 32'(rspv4), (d == 6) ? 32'b0010 : 32'd0);
            if (d == 6) chk("flush_new_rspd", rspd4, F6);
        end

        // Asynchronous reset mid-stream (pointer at 2, moves to 1).
        for (int i = 0; i < 3; i++) begin
            step();
            rv4 = 4'b1111;
        end
        step();
        rv4 = 4'b1001;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fv", 32'(fv4), 32'd0);
        chk("arst_fa", fa4, 32'd0);
        chk("arst_busy", 32'(busy4), 32'd0);
        chk("arst_rspv", 32'(rspv4), 32'd0);
        chk("arst_rspd", rspd4, 32'd0);
        chk("arst_rdy", 32'(rdy4), 32'd0);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_first_grant", 32'(rdy4), 32'b0001);
        for (int d = 1; d <= 5; d++) begin
            step();
            rv4 = 4'b0000;
            @(negedge clk);
            if (d == 1) begin
                chk("arst_fv_after", 32'(fv4), 32'd1);
                chk("arst_fa_after", fa4, A4[0]);
            end
            chk("arst_rspv_after", 32'(rspv4), (d == 5) ? 32'b0001 : 32'd0);
            if (d == 5) chk("arst_rspd_after", rspd4, F5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_op_arbiter.md
Name: fp_op_arbiter

Overview:
Shares one fixed-latency pipelined floating-point operator (adder/multiplier built on the IEEE754 NX/NM packing) between NREQ requesters. Round-robin arbitration issues at most one operation per cycle. A tag pipeline tracks the owner of each in-flight operation and routes every result back to the requester that issued it. Sits between requester blocks and the shared FP unit in the datapath.

Parameters:
NX, 8, exponent width
NM, 23, mantissa width; N = NX + NM + 1 is the operand/result width
NREQ, 4, number of requesters, 2..16
LAT, 3, FP unit latency in cycles from fpu_valid to fpu_res, >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous; drops all in-flight operations
req_valid  in  NREQ  per-requester operation request
req_ready  out  NREQ  per-requester grant; one-hot or zero
req_a  in  NREQ*N  operand A; requester i uses bits [i*N +: N]
req_b  in  NREQ*N  operand B; same slicing as req_a
fpu_valid  out  1  issue strobe to the FP unit
fpu_a  out  N  operand A to the FP unit
fpu_b  out  N  operand B to the FP unit
fpu_res  in  N  FP unit result; valid exactly LAT cycles after the matching fpu_valid cycle
rsp_valid  out  NREQ  one-hot or zero; marks the owner of rsp_data
rsp_data  out  N  result returned to the requester
busy  out  1  high while any operation is issued but not yet returned

Behaviour:
- Reset (async, rst=1): fpu_valid=0, fpu_a=fpu_b=0, rsp_valid=0, rsp_data=0, rr pointer=0, all tag-pipe valids=0, busy=0. req_ready=0 while rst=1.
- Arbitration (combinational): scan req_valid starting at rr pointer, wrapping modulo NREQ. req_ready[i]=1 for the first valid requester found. No grant when flush=1. A handshake is req_valid[i] & req_ready[i] in the same cycle.
- Pointer update: a grant to i sets rr = (i+1) mod NREQ at the next edge (wraps from NREQ-1 to 0). With no grant, rr is unchanged.
- Issue (registered): a handshake in cycle h drives fpu_valid=1 and fpu_a/fpu_b = the granted slices in cycle h+1. With no handshake, fpu_valid=0 and fpu_a/fpu_b hold their values.
- Tag pipeline:
  - LAT+1 stages of {valid, owner index (clog2(NREQ) bits)}.
  - Stage 0 is aligned with fpu_valid; stage k is aligned with cycle h+1+k.
  - At stage LAT, fpu_res is captured: rsp_data <= fpu_res and rsp_valid <= one-hot(owner), presented in cycle h+2+LAT.
  - rsp_data holds its value when there is no response; rsp_valid is a single-cycle pulse.
- Throughput: one issue per cycle, sustained. Responses return in issue order and have no backpressure; requesters must accept them.
- busy = OR of all tag-stage valid bits (does not include rsp_valid).
- flush=1 at an edge: all tag valids <= 0, fpu_valid <= 0, rsp_valid <= 0 next cycle, no grant that cycle, rr unchanged. Results of dropped operations are never presented, even though the FP unit still produces them.
- flush and reset mid-operation: all in-flight work is discarded. The first post-flush/post-reset grant returns normally.
- Boundaries:
  - Only one requester valid: it is granted every cycle, regardless of rr.
  - NREQ not a power of 2: pointer wraps at NREQ, never at 2^k.
  - req_valid dropped without a handshake: no side effects.

Test Plan:
- NREQ=4, LAT=3, FP unit stub = adder. Requester 2 issues once in cycle 10 (a=1.0, b=2.0) -> fpu_valid in cycle 11; rsp_valid=4'b0100 and rsp_data=3.0 in cycle 15; busy high in cycles 11-14 only.
- All four requesters valid continuously for 12 cycles -> grant order 0,1,2,3,0,1,2,3,…; one issue per cycle; each rsp_valid owner matches the issuer; each result equals its a+b.
- Sparse pattern: rr=1 and only requesters 0 and 3 valid -> grant 3, then 0, then 3; a requester that goes idle is skipped without a bubble.
- Issue three ops in consecutive cycles, then assert flush one cycle after the last issue -> no rsp_valid for any of them; busy=0 the next cycle; a new request right after the flush returns correctly at h+2+LAT.
- Assert rst asynchronously mid-stream (not on a clock edge) -> all outputs go to reset values immediately; rr=0 after release; the first grant goes to the lowest-index valid requester.
- NREQ=3, LAT=1, all requesters valid -> wrap 2->0 observed; latency h+3; no out-of-range owner index ever appears on rsp_valid.
